// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a byte + odd parity + stop on device clocks, then checks the ack bit.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned SETUP_CYCLES   = 200,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       sh_q, sh_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_err_q, timeout_err_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall, accept, timing, tmo_hit, line_idle;

    assign fall      = clk_prev_q & ~clk_s2_q;
    assign accept    = (state_q == S_IDLE) & tx_start & ~busy_q;
    assign timing    = (state_q == S_SHIFT) | (state_q == S_ACK) | (state_q == S_WAIT_IDLE);
    assign tmo_hit   = timing & (tmo_q == TMO_LAST);
    assign line_idle = clk_s2_q & data_s2_q;

    // Synchronisers reset high (idle bus level) so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            data_s1_q     <= 1'b1;
            data_s2_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            bitcnt_q      <= '0;
            sh_q          <= '0;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            clk_s1_q      <= ps2_clk_in;
            clk_s2_q      <= clk_s1_q;
            clk_prev_q    <= clk_s2_q;
            data_s1_q     <= ps2_data_in;
            data_s2_q     <= data_s1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            bitcnt_q      <= bitcnt_d;
            sh_q          <= sh_d;
            clk_oe_q      <= clk_oe_d;
            data_oe_q     <= data_oe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_INHIBIT;
            S_INHIBIT:   if (cnt_q == INH_LAST) state_d = S_REQ;
            S_REQ:       if (cnt_q == SET_LAST) state_d = S_SHIFT;
            S_SHIFT: begin
                if (tmo_hit)                          state_d = S_IDLE;
                else if (fall && bitcnt_q == 4'd9)    state_d = S_ACK;
            end
            S_ACK: begin
                if (tmo_hit)   state_d = S_IDLE;
                else if (fall) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (tmo_hit || line_idle) state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        bitcnt_d      = bitcnt_q;
        sh_d          = sh_q;
        clk_oe_d      = clk_oe_q;
        data_oe_d     = data_oe_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ack_err_d     = ack_err_q;
        timeout_err_d = timeout_err_q;

        // busy stays up through the done cycle so a same-cycle tx_start is refused.
        if (done_q) busy_d = 1'b0;

        if (timing) tmo_d = tmo_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d          = {1'b1, ~^tx_data, tx_data};
                    busy_d        = 1'b1;
                    clk_oe_d      = 1'b1;
                    data_oe_d     = 1'b0;
                    cnt_d         = '0;
                    ack_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                if (cnt_q == SET_LAST) begin
                    clk_oe_d = 1'b0;
                    bitcnt_d = '0;
                    tmo_d    = '0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                if (tmo_hit) begin
                    clk_oe_d      = 1'b0;
                    data_oe_d     = 1'b0;
                    done_d        = 1'b1;
                    timeout_err_d = 1'b1;
                    ack_err_d     = 1'b0;
                end else if (state_q == S_SHIFT) begin
                    if (fall) begin
                        data_oe_d = ~sh_q[bitcnt_q];
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) ack_err_d = data_s2_q;
                end else if (line_idle) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural PS/2 device that
// clocks the frame in, acks or nacks, and a byte-level reference model.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int SET  = 5;
    localparam int TMO  = 5000;
    localparam int HALF = 15;

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
    logic       dev_clk, dev_data;
    logic       clk_line, data_line;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int dev_fall_cnt;

    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- reference model ----------------
    // Frame as the device sees it, LSB first: data[0..7], odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic device_run(input bit nack, input int abort_at,
                              output logic [9:0] bits, output logic start_bit, output bit ok);
        int n;
        ok = 0;
        bits = '0;
        start_bit = 1'b1;
        dev_fall_cnt = 0;
        n = 0;
        while (!(busy && ps2_data_oe && !ps2_clk_oe) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) return;
        repeat ($urandom_range(3, 12)) @(negedge clk);
        start_bit = data_line;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_data = nack;
            dev_clk = 1'b0;
            dev_fall_cnt++;
            if (i == abort_at) begin
                repeat (5) @(negedge clk);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) begin
                bits[i] = data_line;
                repeat (HALF) @(negedge clk);
            end else begin
                dev_data = 1'b1;
            end
        end
        ok = 1;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic ae, output logic te,
                             output logic coe, output logic doe);
        int n;
        seen = 0; ae = 1'bx; te = 1'bx; coe = 1'bx; doe = 1'bx;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1; ae = ack_err; te = timeout_err; coe = ps2_clk_oe; doe = ps2_data_oe;
                return;
            end
            n++;
        end
    endtask

    // One complete transfer with frame, done, flag and done-count checks.
    task automatic run_and_check(input logic [7:0] b, input bit nack, input string name);
        logic [9:0] bits, exp;
        logic sb, ae, te, coe, doe;
        bit ok, seen;
        int d0;
        d0 = done_cnt;
        exp = model_frame(b);
        send_byte(b);
        device_run(nack, -1, bits, sb, ok);
        wait_done(200, seen, ae, te, coe, doe);
        repeat (5) @(negedge clk);
        tests_run++;
        if (!ok || bits !== exp || sb !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s frame: got start=%b bits=%b ok=%0d required start=0 bits=%b", name, sb, bits, ok, exp);
        end
        tests_run++;
        if (!seen || (done_cnt - d0) != 1) begin
            tests_failed++;
            $display("FAIL %s done: got seen=%0d pulses=%0d required 1", name, seen, done_cnt - d0);
        end
        tests_run++;
        if (ae !== nack || te !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s flags: got ack_err=%b timeout_err=%b required %b 0", name, ae, te, nack);
        end
        tests_run++;
        if (coe !== 1'b0 || doe !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s release: got clk_oe=%b data_oe=%b busy=%b required 0 0 0", name, coe, doe, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset outputs: got %b required 000000",
                     {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err});
        end
    endtask

    task automatic test_send_ed();
        run_and_check(8'hED, 1'b0, "send_ed");
    endtask

    task automatic test_parity();
        logic [7:0] vals[6];
        vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'hFF;
        for (int i = 3; i < 6; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) run_and_check(vals[i], 1'b0, $sformatf("parity_%02h", vals[i]));
    endtask

    task automatic test_nack();
        run_and_check(8'($urandom_range(0, 255)), 1'b1, "nack");
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        logic ae, te, coe, doe;
        send_byte(8'hED);
        n = 0;
        while (ps2_clk_oe && n < 300) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        seen = 0;
        while (n < TMO + 100) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        ae = ack_err; te = timeout_err; coe = ps2_clk_oe; doe = ps2_data_oe;
        tests_run++;
        if (!seen || n != TMO) begin
            tests_failed++;
            $display("FAIL timeout latency: got seen=%0d cycles=%0d required %0d", seen, n, TMO);
        end
        tests_run++;
        if (te !== 1'b1 || ae !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout flags: got timeout_err=%b ack_err=%b required 1 0", te, ae);
        end
        tests_run++;
        if (coe !== 1'b0 || doe !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout release: got clk_oe=%b data_oe=%b required 0 0", coe, doe);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [9:0] bits, exp;
        logic sb, ae, te, coe, doe;
        bit ok, seen;
        int d0;
        d0 = done_cnt;
        exp = model_frame(8'hED);
        send_byte(8'hED);
        fork
            device_run(1'b0, -1, bits, sb, ok);
            begin
                int n;
                n = 0;
                while (dev_fall_cnt < 3 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_done(200, seen, ae, te, coe, doe);
        repeat (20) @(negedge clk);
        tests_run++;
        if (!ok || bits !== exp) begin
            tests_failed++;
            $display("FAIL busy_ignore frame: got bits=%b ok=%0d required %b", bits, ok, exp);
        end
        tests_run++;
        if (!seen || (done_cnt - d0) != 1 || busy !== 1'b0 || ae !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore done: got pulses=%0d busy=%b ack_err=%b required 1 0 0",
                     done_cnt - d0, busy, ae);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic sb;
        bit ok;
        int d0;
        d0 = done_cnt;
        send_byte(8'hED);
        device_run(1'b0, 4, bits, sb, ok);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid outputs: got clk_oe=%b data_oe=%b busy=%b done=%b required 0 0 0 0",
                     ps2_clk_oe, ps2_data_oe, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests_run++;
        if (done_cnt != d0) begin
            tests_failed++;
            $display("FAIL reset_mid done: got pulses=%0d required 0", done_cnt - d0);
        end
        run_and_check(8'hF4, 1'b0, "after_reset_f4");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        dev_fall_cnt = 0;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_send_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
